// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock from a
// single shared subtractor, with zero-divisor short-circuit to DONE.
module seq_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH:0]   p_q, p_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      shifted = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
      trial   = shifted - {1'b0, d_q};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  p_d     = '0;
                  q_d     = dividend;
                  d_d     = divisor;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end else begin
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            // A negative trial (MSB set) keeps the shifted value: the restore step.
            if (!trial[WIDTH]) begin
               p_d = trial;
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               p_d = shifted;
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               quo_d   = q_d;
               rem_d   = p_d[WIDTH-1:0];
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=4): latency, boundaries,
// zero divisor, ignored starts, asynchronous abort and a full operand sweep.
`timescale 1ns/1ps
module tb_seq_restoring_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issues one request and waits (bounded) for done; lat counts edges from
   // the start cycle to the done cycle.
   task automatic run(input int a, input int b, output int lat, output int bcnt);
      @(negedge clk);
      start    = 1'b1;
      dividend = W'(a);
      divisor  = W'(b);
      lat  = 0;
      bcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (busy) bcnt++;
         if (done) break;
      end
   endtask

   initial begin
      int lat, bcnt, dones;

      #1;
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run(13, 3, lat, bcnt);
      $display("13/3 -> q=%0d r=%0d dbz=%0d lat=%0d busy=%0d", quotient, remainder, div_by_zero, lat, bcnt);
      chk("13/3_lat", lat, 5);
      chk("13/3_busy", bcnt, 4);
      chk("13/3_q", quotient, 4);
      chk("13/3_r", remainder, 1);
      chk("13/3_dbz", div_by_zero, 0);
      @(negedge clk);
      chk("13/3_done_pulse", done, 0);

      run(15, 1, lat, bcnt);
      $display("15/1 -> q=%0d r=%0d", quotient, remainder);
      chk("15/1_q", quotient, 15);
      chk("15/1_r", remainder, 0);

      run(7, 9, lat, bcnt);
      $display("7/9 -> q=%0d r=%0d", quotient, remainder);
      chk("7/9_q", quotient, 0);
      chk("7/9_r", remainder, 7);
      dividend = 4'd11;
      divisor  = 4'd2;
      repeat (3) @(negedge clk);
      chk("hold_q", quotient, 0);
      chk("hold_r", remainder, 7);

      run(9, 0, lat, bcnt);
      $display("9/0 -> q=%0d r=%0d dbz=%0d lat=%0d busy=%0d", quotient, remainder, div_by_zero, lat, bcnt);
      chk("9/0_lat", lat, 1);
      chk("9/0_busy", bcnt, 0);
      chk("9/0_q", quotient, 15);
      chk("9/0_r", remainder, 9);
      chk("9/0_dbz", div_by_zero, 1);

      run(8, 2, lat, bcnt);
      $display("8/2 -> q=%0d r=%0d dbz=%0d", quotient, remainder, div_by_zero);
      chk("8/2_q", quotient, 4);
      chk("8/2_r", remainder, 0);
      chk("8/2_dbz", div_by_zero, 0);

      // Starts pulsed mid-run and in the DONE cycle must be ignored.
      @(negedge clk);
      start    = 1'b1;
      dividend = 4'd13;
      divisor  = 4'd3;
      dones    = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            dones++;
            start    = 1'b1;
            dividend = 4'd2;
            divisor  = 4'd0;
         end else if (busy && i == 1) begin
            start    = 1'b1;
            dividend = 4'd15;
            divisor  = 4'd1;
         end
      end
      $display("ignored-start -> q=%0d r=%0d dbz=%0d dones=%0d", quotient, remainder, div_by_zero, dones);
      chk("ign_dones", dones, 1);
      chk("ign_q", quotient, 4);
      chk("ign_r", remainder, 1);
      chk("ign_dbz", div_by_zero, 0);

      // Asynchronous abort during iteration 2 of 14/5.
      @(negedge clk);
      start    = 1'b1;
      dividend = 4'd14;
      divisor  = 4'd5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      $display("abort -> q=%0d r=%0d busy=%0d done=%0d", quotient, remainder, busy, done);
      chk("abort_q", quotient, 0);
      chk("abort_r", remainder, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("abort_no_done", dones, 0);
      run(14, 5, lat, bcnt);
      $display("14/5 -> q=%0d r=%0d", quotient, remainder);
      chk("14/5_q", quotient, 2);
      chk("14/5_r", remainder, 4);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run(a, b, lat, bcnt);
            $display("sweep %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, quotient, remainder, div_by_zero, lat);
            if (b == 0) begin
               chk("sweep_z_q", quotient, 15);
               chk("sweep_z_r", remainder, a);
               chk("sweep_z_dbz", div_by_zero, 1);
               chk("sweep_z_lat", lat, 1);
            end else begin
               chk("sweep_q", quotient, a / b);
               chk("sweep_r", remainder, a % b);
               chk("sweep_dbz", div_by_zero, 0);
               chk("sweep_lat", lat, 5);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
